// File: rtl/network_bf_out_pipe_pkg.sv
// Shared helpers for the butterfly output network: select/counter widths and
// lane/BFU packing offsets.
package net_pkg;

    function automatic int calc_selw(input int num_lanes);
        return (num_lanes <= 2) ? 1 : $clog2(num_lanes);
    endfunction

    function automatic int calc_cntw(input int depth);
        return (depth < 1) ? 1 : $clog2(depth + 1);
    endfunction

    // Bit offset of element idx in a flat bus of elem_w-wide fields
    function automatic int pack_lsb(input int idx, input int elem_w);
        return idx * elem_w;
    endfunction

endpackage

// File: rtl/network_bf_out_pipe_sel_delay_line.sv
// Valid + payload shift register, async reset, synchronous clear of all valids.
module sel_delay_line #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             in_vld,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_vld,
    output logic [WIDTH-1:0] out_data
);

    logic [DEPTH-1:0]            vld_pipe;
    logic [DEPTH-1:0][WIDTH-1:0] dat_pipe;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe <= '0;
            dat_pipe <= '0;
        end else begin
            // Payload keeps shifting on clear; only the valid bits matter downstream
            for (int i = DEPTH - 1; i >= 1; i--) begin
                vld_pipe[i] <= vld_pipe[i-1] & ~clr;
                dat_pipe[i] <= dat_pipe[i-1];
            end
            vld_pipe[0] <= in_vld & ~clr;
            dat_pipe[0] <= in_data;
        end
    end

    assign out_vld  = vld_pipe[DEPTH-1];
    assign out_data = dat_pipe[DEPTH-1];

endmodule

// File: rtl/network_bf_out_pipe.sv
// Routes BFU upper/lower results to bank write lanes using selects issued
// SEL_DELAY cycles earlier. Optional duplicate-route check: NETWORK_BF_OUT_DUPCHK_EN.
module network_bf_out_pipe
    import net_pkg::*;
#(
    parameter int DATA_WIDTH = 14,
    parameter int NUM_BFU    = 4,
    parameter int SEL_DELAY  = 13,
    localparam int NUM_LANES = 2 * NUM_BFU,
    localparam int SELW      = calc_selw(NUM_LANES),
    localparam int CNTW      = calc_cntw(SEL_DELAY)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            flush,
    input  logic                            sel_valid,
    input  logic [NUM_LANES*SELW-1:0]       sel,
    input  logic [NUM_BFU*DATA_WIDTH-1:0]   bf_upper,
    input  logic [NUM_BFU*DATA_WIDTH-1:0]   bf_lower,
    output logic [NUM_LANES*DATA_WIDTH-1:0] d,
    output logic                            d_valid,
    output logic [CNTW-1:0]                 in_flight,
    output logic                            dup_err
);

    logic                                 vld_d;
    logic [NUM_LANES*SELW-1:0]            sel_d;
    logic [NUM_LANES-1:0][SELW-1:0]       sel_lane;
    logic [NUM_LANES-1:0][DATA_WIDTH-1:0] mux;
    logic                                 enter;

    assign enter = sel_valid & ~flush;

    sel_delay_line #(
        .WIDTH (NUM_LANES * SELW),
        .DEPTH (SEL_DELAY)
    ) u_sel_dly (
        .clk      (clk),
        .rst      (rst),
        .clr      (flush),
        .in_vld   (sel_valid),
        .in_data  (sel),
        .out_vld  (vld_d),
        .out_data (sel_d)
    );

    assign sel_lane = sel_d;

    // Select s: BFU s>>1, upper when s is odd; values past the last lane route 0
    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
        int b;
        assign b = pack_lsb(int'(sel_lane[k]) >> 1, DATA_WIDTH);
        assign mux[k] = (int'(sel_lane[k]) >= NUM_LANES) ? '0 :
                        sel_lane[k][0] ? bf_upper[b +: DATA_WIDTH]
                                       : bf_lower[b +: DATA_WIDTH];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d       <= '0;
            d_valid <= 1'b0;
        end else if (vld_d && !flush) begin
            d       <= mux;
            d_valid <= 1'b1;
        end else begin
            d_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_flight <= '0;
        end else if (flush) begin
            in_flight <= '0;
        end else begin
            case ({enter, vld_d})
                2'b10:   in_flight <= in_flight + CNTW'(1);
                2'b01:   in_flight <= in_flight - CNTW'(1);
                default: in_flight <= in_flight;
            endcase
        end
    end

`ifdef NETWORK_BF_OUT_DUPCHK_EN
    logic dup_hit;

    always_comb begin
        dup_hit = 1'b0;
        for (int i = 0; i < NUM_LANES; i++) begin
            for (int j = i + 1; j < NUM_LANES; j++) begin
                if (sel_lane[i] == sel_lane[j] && int'(sel_lane[i]) < NUM_LANES)
                    dup_hit = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            dup_err <= 1'b0;
        else if (flush)
            dup_err <= 1'b0;
        else if (vld_d && dup_hit)
            dup_err <= 1'b1;
    end
`else
    assign dup_err = 1'b0;
`endif

endmodule

// File: tb/tb_network_bf_out_pipe.sv
// Randomized scoreboard bench for network_bf_out_pipe plus a directed check on a
// non-power-of-2 instance (3 BFUs, delay 2).
module tb_network_bf_out_pipe;

    localparam int DW = 14;
    localparam int NB = 4;
    localparam int D  = 13;
    localparam int NL = 8;
    localparam int SW = 3;
    localparam int CW = 4;

    localparam int PNB = 3;
    localparam int PNL = 6;
    localparam int PD  = 2;

    logic              clk = 1'b0;
    logic              rst, flush, sel_valid;
    logic [NL*SW-1:0]  sel;
    logic [NB*DW-1:0]  bf_upper, bf_lower;
    logic [NL*DW-1:0]  d;
    logic              d_valid;
    logic [CW-1:0]     in_flight;
    logic              dup_err;

    logic              np_flush, np_sel_valid;
    logic [PNL*SW-1:0] np_sel;
    logic [PNB*DW-1:0] np_bfu, np_bfl;
    logic [PNL*DW-1:0] np_d;
    logic              np_d_valid;
    logic [1:0]        np_in_flight;
    logic              np_dup_err;

    always #5 clk = ~clk;

    network_bf_out_pipe u_dut (
        .clk(clk), .rst(rst), .flush(flush), .sel_valid(sel_valid), .sel(sel),
        .bf_upper(bf_upper), .bf_lower(bf_lower), .d(d), .d_valid(d_valid),
        .in_flight(in_flight), .dup_err(dup_err)
    );

    network_bf_out_pipe #(.DATA_WIDTH(DW), .NUM_BFU(PNB), .SEL_DELAY(PD)) u_np (
        .clk(clk), .rst(rst), .flush(np_flush), .sel_valid(np_sel_valid), .sel(np_sel),
        .bf_upper(np_bfu), .bf_lower(np_bfl), .d(np_d), .d_valid(np_d_valid),
        .in_flight(np_in_flight), .dup_err(np_dup_err)
    );

    typedef struct { int due; logic [NL*SW-1:0] s; } pend_t;
    typedef struct { logic v; logic [NL*DW-1:0] d; int inf; logic dup; } exp_t;

    pend_t            pq[$];
    exp_t             eq[$];
    logic [NL*DW-1:0] m_d;
    logic             m_dup;
    int               cyc;
    int               checks = 0;
    int               errors = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    // Reference routing: lane k takes BFU s/2, upper if s odd, zero if s out of range
    function automatic logic [NL*DW-1:0] route(input logic [NL*SW-1:0] s);
        logic [NL*DW-1:0] r;
        int v;
        r = '0;
        for (int k = 0; k < NL; k++) begin
            v = int'(s[k*SW +: SW]);
            if (v < NL)
                r[k*DW +: DW] = (v % 2 == 1) ? bf_upper[(v/2)*DW +: DW] : bf_lower[(v/2)*DW +: DW];
        end
        return r;
    endfunction

    function automatic logic has_dup(input logic [NL*SW-1:0] s);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < NL; i++)
            for (int j = i + 1; j < NL; j++)
                if (s[i*SW +: SW] == s[j*SW +: SW] && int'(s[i*SW +: SW]) < NL) hit = 1'b1;
        return hit;
    endfunction

    // One cycle of stimulus; the model works on a queue of pending selects keyed by due cycle
    task automatic step(input logic sv, input logic [NL*SW-1:0] s, input logic fl, input logic rs);
        exp_t  e;
        pend_t p;
        logic  v;
        @(negedge clk);
        rst = rs; flush = fl; sel_valid = sv; sel = s;
        for (int b = 0; b < NB; b++) begin
            bf_upper[b*DW +: DW] = DW'($urandom);
            bf_lower[b*DW +: DW] = DW'($urandom);
        end
        v = 1'b0;
        if (rs) begin
            pq.delete(); m_d = '0; m_dup = 1'b0;
        end else if (fl) begin
            pq.delete(); m_dup = 1'b0;
        end else begin
            if (pq.size() > 0 && pq[0].due == cyc) begin
                p = pq.pop_front();
                v = 1'b1;
                m_d = route(p.s);
`ifdef NETWORK_BF_OUT_DUPCHK_EN
                if (has_dup(p.s)) m_dup = 1'b1;
`endif
            end
            if (sv) begin
                p.due = cyc + D; p.s = s;
                pq.push_back(p);
            end
        end
        e.v = v; e.d = m_d; e.inf = pq.size(); e.dup = m_dup;
        eq.push_back(e);
        cyc++;
    endtask

    function automatic logic [NL*SW-1:0] rnd_sel();
        logic [NL*SW-1:0] r;
        r = '0;
        for (int k = 0; k < NL; k++) r[k*SW +: SW] = SW'($urandom);
        return r;
    endfunction

    // Monitor: compares each post-edge output against the model's entry for that edge
    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (eq.size() > 0) begin
                e = eq.pop_front();
                chk("d_valid", 128'(d_valid), 128'(e.v));
                chk("d", 128'(d), 128'(e.d));
                chk("in_flight", 128'(in_flight), 128'(e.inf));
                chk("dup_err", 128'(dup_err), 128'(e.dup));
            end
        end
    end

    initial begin : driver
        logic [NL*SW-1:0]  s;
        logic [NL*SW-1:0]  id_sel;
        logic [PNB*DW-1:0] u_c, l_c;
        logic [PNL*DW-1:0] np_exp;
        rst = 1'b1; flush = 1'b0; sel_valid = 1'b0; sel = '0;
        bf_upper = '0; bf_lower = '0;
        np_flush = 1'b0; np_sel_valid = 1'b0; np_sel = '0; np_bfu = '0; np_bfl = '0;
        m_d = '0; m_dup = 1'b0; cyc = 0;

        for (int i = 0; i < 3; i++) step(1'b1, rnd_sel(), 1'b0, 1'b1);
        for (int i = 0; i < 15; i++) step(1'b0, '0, 1'b0, 1'b0);

        id_sel = '0;
        for (int k = 0; k < NL; k++) id_sel[k*SW +: SW] = SW'(k);
        step(1'b1, id_sel, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) step(1'b0, '0, 1'b0, 1'b0);

        for (int i = 0; i < 20; i++) begin
            s = rnd_sel();
            s[SW-1:0] = SW'(i % NL);
            step(1'b1, s, 1'b0, 1'b0);
        end
        for (int i = 0; i < 16; i++) step(1'b0, '0, 1'b0, 1'b0);

        for (int i = 0; i < 5; i++) step(1'b1, rnd_sel(), (i == 3), 1'b0);
        for (int i = 0; i < 16; i++) step(1'b0, '0, 1'b0, 1'b0);

        for (int i = 0; i < 400; i++)
            step(($urandom % 4) != 0, rnd_sel(), ($urandom % 30) == 0, ($urandom % 180) == 0);
        for (int i = 0; i < 16; i++) step(1'b0, '0, 1'b0, 1'b0);

        @(posedge clk); #2;
        chk("scoreboard_drained", 128'(eq.size()), 128'(0));

        // Non-power-of-2 instance: out-of-range selects route zero
        for (int b = 0; b < PNB; b++) begin
            np_bfu[b*DW +: DW] = DW'($urandom) | DW'(1);
            np_bfl[b*DW +: DW] = DW'($urandom) | DW'(1);
        end
        @(negedge clk);
        np_sel = {3'd4, 3'd0, 3'd1, 3'd6, 3'd5, 3'd7};
        np_sel_valid = 1'b1;
        @(negedge clk);
        np_sel_valid = 1'b0;
        @(negedge clk);
        for (int b = 0; b < PNB; b++) begin
            np_bfu[b*DW +: DW] = DW'($urandom) | DW'(1);
            np_bfl[b*DW +: DW] = DW'($urandom) | DW'(1);
        end
        u_c = np_bfu; l_c = np_bfl;
        np_exp = {l_c[2*DW +: DW], l_c[0 +: DW], u_c[0 +: DW], DW'(0), u_c[2*DW +: DW], DW'(0)};
        @(posedge clk); #1;
        chk("np_d_valid", 128'(np_d_valid), 128'(1));
        chk("np_d", 128'(np_d), 128'(np_exp));
        chk("np_in_flight", 128'(np_in_flight), 128'(0));
        @(posedge clk); #1;
        chk("np_d_valid_once", 128'(np_d_valid), 128'(0));
        chk("np_d_hold", 128'(np_d), 128'(np_exp));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
